// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_arb_rr_arb2.sv
// Combinational two-way picker: round-robin on ties, or port 0 wins ties when FIXED_PRIO is set.
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        unique case (req)
            2'b01:   winner = PORT_CPU;
            2'b10:   winner = PORT_DMA;
            2'b11:   winner = FIXED_PRIO ? PORT_CPU : ~last_grant;
            default: winner = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the 256x8 data memory between the CPU port (0) and the DMA/debug port (1),
// turning req/gnt handshakes into registered memory strobes and returning read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    state_t            state, state_n;
    logic              last_grant, last_grant_n;
    logic              lat_idx, lat_idx_n;
    logic [1:0]        gnt_q, gnt_n;
    logic [1:0]        rvalid_q, rvalid_n;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_n [2];
    logic              mem_wr_n, mem_rd_n, busy_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_data_in_n;

    logic              pick, pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_pick (
        .req       ({p1_req, p0_req}),
        .last_grant(last_grant),
        .winner    (pick),
        .valid     (pick_valid)
    );

    assign sel_we    = pick ? p1_we    : p0_we;
    assign sel_addr  = pick ? p1_addr  : p0_addr;
    assign sel_wdata = pick ? p1_wdata : p0_wdata;

    always_comb begin
        state_n       = state;
        last_grant_n  = last_grant;
        lat_idx_n     = lat_idx;
        mem_wr_n      = 1'b0;
        mem_rd_n      = 1'b0;
        mem_addr_n    = '0;
        mem_data_in_n = '0;
        busy_n        = 1'b0;
        gnt_n         = '0;
        rvalid_n      = '0;
        rdata_n[0]    = rdata_q[0];
        rdata_n[1]    = rdata_q[1];

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n        = ACCESS;
                    last_grant_n   = pick;
                    lat_idx_n      = pick;
                    mem_wr_n       = sel_we;
                    mem_rd_n       = ~sel_we;
                    mem_addr_n     = sel_addr;
                    mem_data_in_n  = sel_we ? sel_wdata : '0;
                    busy_n         = 1'b1;
                    gnt_n[pick]    = 1'b1;
                end
            end
            ACCESS: begin
                // Memory output is valid now because mem_rd has been high for the whole cycle.
                state_n = IDLE;
                if (mem_rd) begin
                    rdata_n[lat_idx]  = mem_data_out;
                    rvalid_n[lat_idx] = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_DMA;
            lat_idx     <= PORT_CPU;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            lat_idx     <= lat_idx_n;
            gnt_q       <= gnt_n;
            rvalid_q    <= rvalid_n;
            rdata_q[0]  <= rdata_n[0];
            rdata_q[1]  <= rdata_n[1];
            mem_wr      <= mem_wr_n;
            mem_rd      <= mem_rd_n;
            mem_addr    <= mem_addr_n;
            mem_data_in <= mem_data_in_n;
            busy        <= busy_n;
        end
    end

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_rdata  = rdata_q[0];
    assign p1_rdata  = rdata_q[1];

endmodule
